// File: rtl/mul_pipe.sv
// Four-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) alongside the ALU path.
// Exposes an in-flight destination mask so decode can stall dependent instructions.
module mul_pipe #(
    parameter int WD_SIZE  = 32,
    parameter int REG_SIZE = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [2:0]               funct3_i,
    input  logic [WD_SIZE-1:0]       op1_data_i,
    input  logic [WD_SIZE-1:0]       op2_data_i,
    input  logic [REG_SIZE-1:0]      rd_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic                     valid_result_o,
    output logic [WD_SIZE-1:0]       mult_result_o,
    output logic [REG_SIZE-1:0]      rd_o,
    output logic [2**REG_SIZE-1:0]   rd_busy_o,
    output logic                     busy_o
);

    localparam int HALF = WD_SIZE / 2;
    localparam int EW   = WD_SIZE + 1;
    localparam int PW   = 2 * (HALF + 1);
    localparam int SW   = 2 * WD_SIZE;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_t;

    op_t             op;
    logic            accept;
    logic            sext1;
    logic            sext2;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;

    always_comb begin
        op     = op_t'(funct3_i[1:0]);
        accept = valid_i && !funct3_i[2] && !stall_i && !flush_i;
        sext1  = (op == OP_MULH) || (op == OP_MULHSU);
        sext2  = (op == OP_MULH);
        a_ext  = {sext1 & op1_data_i[WD_SIZE-1], op1_data_i};
        b_ext  = {sext2 & op2_data_i[WD_SIZE-1], op2_data_i};
    end

    logic                 s1_valid, s2_valid, s3_valid;
    logic [EW-1:0]        s1_a, s1_b;
    logic                 s1_hi, s2_hi, s3_hi;
    logic [REG_SIZE-1:0]  s1_rd, s2_rd, s3_rd;
    logic signed [PW-1:0] s2_ll, s2_lh, s2_hl, s2_hh;
    logic signed [SW-1:0] s3_sum;

    // Split each 33-bit operand into an unsigned 16-bit low half and a signed 17-bit high half.
    logic signed [HALF:0] a_lo, a_hi, b_lo, b_hi;
    logic signed [PW-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic signed [SW-1:0] sum_d;

    always_comb begin
        a_lo  = {1'b0, s1_a[HALF-1:0]};
        a_hi  = s1_a[EW-1:HALF];
        b_lo  = {1'b0, s1_b[HALF-1:0]};
        b_hi  = s1_b[EW-1:HALF];
        pp_ll = PW'(a_lo) * PW'(b_lo);
        pp_lh = PW'(a_lo) * PW'(b_hi);
        pp_hl = PW'(a_hi) * PW'(b_lo);
        pp_hh = PW'(a_hi) * PW'(b_hi);
    end

    // Bits above the 64-bit product never reach the output, so the sum is kept at product width.
    always_comb begin
        sum_d = SW'(s2_ll)
              + (SW'(s2_lh) <<< HALF)
              + (SW'(s2_hl) <<< HALF)
              + (SW'(s2_hh) <<< (2 * HALF));
    end

    // Flush wins over stall so a frozen pipeline can still be emptied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            s3_valid       <= 1'b0;
            valid_result_o <= 1'b0;
        end else if (flush_i) begin
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            s3_valid       <= 1'b0;
            valid_result_o <= 1'b0;
        end else if (!stall_i) begin
            s1_valid       <= accept;
            s2_valid       <= s1_valid;
            s3_valid       <= s2_valid;
            valid_result_o <= s3_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_a          <= '0;
            s1_b          <= '0;
            s1_hi         <= 1'b0;
            s1_rd         <= '0;
            s2_ll         <= '0;
            s2_lh         <= '0;
            s2_hl         <= '0;
            s2_hh         <= '0;
            s2_hi         <= 1'b0;
            s2_rd         <= '0;
            s3_sum        <= '0;
            s3_hi         <= 1'b0;
            s3_rd         <= '0;
            mult_result_o <= '0;
            rd_o          <= '0;
        end else if (!stall_i) begin
            s1_a          <= a_ext;
            s1_b          <= b_ext;
            s1_hi         <= (op != OP_MUL);
            s1_rd         <= rd_i;
            s2_ll         <= pp_ll;
            s2_lh         <= pp_lh;
            s2_hl         <= pp_hl;
            s2_hh         <= pp_hh;
            s2_hi         <= s1_hi;
            s2_rd         <= s1_rd;
            s3_sum        <= sum_d;
            s3_hi         <= s2_hi;
            s3_rd         <= s2_rd;
            mult_result_o <= s3_hi ? s3_sum[SW-1:WD_SIZE] : s3_sum[WD_SIZE-1:0];
            rd_o          <= s3_rd;
        end
    end

    always_comb begin
        rd_busy_o = '0;
        if (s1_valid)       rd_busy_o[s1_rd] = 1'b1;
        if (s2_valid)       rd_busy_o[s2_rd] = 1'b1;
        if (s3_valid)       rd_busy_o[s3_rd] = 1'b1;
        if (valid_result_o) rd_busy_o[rd_o]  = 1'b1;
        rd_busy_o[0] = 1'b0;
        busy_o = s1_valid | s2_valid | s3_valid | valid_result_o;
    end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_mul_pipe;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] op1_data_i;
    logic [31:0] op2_data_i;
    logic [4:0]  rd_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_result_o;
    logic [31:0] mult_result_o;
    logic [4:0]  rd_o;
    logic [31:0] rd_busy_o;
    logic        busy_o;

    mul_pipe #(.WD_SIZE(32), .REG_SIZE(5)) dut (
        .clk(clk),
        .reset(reset),
        .valid_i(valid_i),
        .funct3_i(funct3_i),
        .op1_data_i(op1_data_i),
        .op2_data_i(op2_data_i),
        .rd_i(rd_i),
        .stall_i(stall_i),
        .flush_i(flush_i),
        .valid_result_o(valid_result_o),
        .mult_result_o(mult_result_o),
        .rd_o(rd_o),
        .rd_busy_o(rd_busy_o),
        .busy_o(busy_o)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && valid_result_o && !stall_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h rd=%0d required=none (cycle %0d)",
                         mult_result_o, rd_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_data", 64'(mult_result_o), 64'(e.data));
                chk("result_rd", 64'(rd_o), 64'(e.rd));
                chk("result_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] e,
                         input int unsigned extra, input bit expected);
        valid_i    = 1'b1;
        funct3_i   = f;
        op1_data_i = a;
        op2_data_i = b;
        rd_i       = rd;
        if (expected) sb.push_back('{e, rd, cyc + 4 + extra});
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) step();
    endtask

    logic [31:0] held_d;
    logic [4:0]  held_r;
    logic        held_v;
    int          pulses;
    int          waited;

    initial begin
        reset = 1'b1; valid_i = 1'b0; funct3_i = '0; op1_data_i = '0; op2_data_i = '0;
        rd_i = '0; stall_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(valid_result_o), 64'd0);
        chk("reset_data", 64'(mult_result_o), 64'd0);
        chk("reset_rd", 64'(rd_o), 64'd0);
        chk("reset_mask", 64'(rd_busy_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        reset = 1'b0;
        step();

        // back-to-back ops, each checked 4 cycles later in order
        drive(F_MUL,    32'd7,         32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 0, 1); step();
        drive(F_MULH,   32'h80000000,  32'h80000000, 5'd6, 32'h40000000, 0, 1); step();
        drive(F_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 0, 1); step();
        drive(F_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 0, 1); step();
        drive(F_MULH,   32'hFFFFFFFF,  32'd2,        5'd1, 32'hFFFFFFFF, 0, 1); step();
        drive(F_MULHU,  32'h80000000,  32'd2,        5'd2, 32'h00000001, 0, 1); step();
        drive(F_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3, 32'h00000001, 0, 1); step();
        idle(6);

        // hazard mask for a single op to rd=12
        drive(F_MUL, 32'd3, 32'd4, 5'd12, 32'd12, 0, 1);
        @(negedge clk); chk("mask_accept_cycle", 64'(rd_busy_o), 64'd0);
        step();
        valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); chk("mask_rd12", 64'(rd_busy_o), 64'h00001000);
            step();
        end
        @(negedge clk); chk("mask_rd12_clear", 64'(rd_busy_o), 64'd0);
        step();

        // rd=0 computes but never shows in the mask
        drive(F_MUL, 32'd3, 32'd3, 5'd0, 32'd9, 0, 1); step();
        valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("mask_rd0", 64'(rd_busy_o), 64'd0);
            chk("busy_rd0", 64'(busy_o), 64'd1);
            step();
        end
        idle(2);

        // stall two cycles after the first accept
        drive(F_MULHU, 32'd3, 32'd5, 5'd9,  32'd0,  2, 1); step();
        drive(F_MUL,   32'd3, 32'd5, 5'd10, 32'd15, 2, 1); step();
        valid_i = 1'b0;
        stall_i = 1'b1;
        @(negedge clk);
        held_d = mult_result_o; held_r = rd_o; held_v = valid_result_o;
        chk("stall_mask", 64'(rd_busy_o), 64'h00000600);
        step();
        @(negedge clk);
        chk("stall_hold_data", 64'(mult_result_o), 64'(held_d));
        chk("stall_hold_rd", 64'(rd_o), 64'(held_r));
        chk("stall_hold_valid", 64'(valid_result_o), 64'(held_v));
        chk("stall_mask2", 64'(rd_busy_o), 64'h00000600);
        step();
        stall_i = 1'b0;
        @(negedge clk);
        chk("stall_hold_data_end", 64'(mult_result_o), 64'(held_d));
        idle(6);

        // flush in the 3rd accept cycle
        drive(F_MUL, 32'd1, 32'd1, 5'd13, 32'd1, 0, 0); step();
        drive(F_MUL, 32'd2, 32'd1, 5'd14, 32'd2, 0, 0); step();
        drive(F_MUL, 32'd3, 32'd1, 5'd15, 32'd3, 0, 0);
        flush_i = 1'b1;
        @(negedge clk); chk("preflush_mask", 64'(rd_busy_o), 64'h00006000);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("postflush_mask", 64'(rd_busy_o), 64'd0);
        chk("postflush_valid", 64'(valid_result_o), 64'd0);
        chk("postflush_busy", 64'(busy_o), 64'd0);
        idle(6);
        drive(F_MUL, 32'd2, 32'd2, 5'd16, 32'd4, 0, 1); step();
        idle(6);

        // funct3 1xx is dropped
        drive(3'b100, 32'd5, 32'd6, 5'd17, 32'd0, 0, 0); step();
        valid_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("ignored_busy", 64'(busy_o), 64'd0);
            chk("ignored_mask", 64'(rd_busy_o), 64'd0);
            step();
        end

        // asynchronous reset with ops in flight
        drive(F_MUL, 32'd4, 32'd4, 5'd20, 32'd16, 0, 0); step();
        drive(F_MUL, 32'd5, 32'd4, 5'd21, 32'd20, 0, 0); step();
        drive(F_MUL, 32'd6, 32'd4, 5'd22, 32'd24, 0, 0); step();
        valid_i = 1'b0;
        step();
        chk("inflight_valid", 64'(valid_result_o), 64'd1);
        chk("inflight_mask", 64'(rd_busy_o), 64'h00700000);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(valid_result_o), 64'd0);
        chk("async_reset_mask", 64'(rd_busy_o), 64'd0);
        chk("async_reset_busy", 64'(busy_o), 64'd0);
        chk("async_reset_data", 64'(mult_result_o), 64'd0);
        chk("async_reset_rd", 64'(rd_o), 64'd0);
        step();
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(valid_result_o);
            step();
        end
        chk("post_reset_pulses", 64'(pulses), 64'd0);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            step();
            waited++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
